pix_word_packer: RTL and testbench

- Sits directly downstream of the filter2d top and consumes its o_strb/o_data pixel stream (one 8-bit pixel per strobe, raster order, IMG_W x IMG_H frames, back-to-back frames).
- Packs 4 consecutive pixels into one 32-bit word and tags row/frame boundaries.
- Buffers words in a small show-ahead FIFO and presents them on a valid/ready interface towards the bus/DMA side.

---
 rtl/pix_word_packer.sv | 127 ++++++++++++
 tb/tb_pix_word_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pix_word_packer.sv
// Packs four raster-order pixels into 32-bit words tagged with end-of-row/end-of-frame, queued in a show-ahead FIFO.
// Latency: word written at the 4th pixel's edge; o_valid rises the next cycle when the FIFO was empty.
// Backpressure: input cannot stall; a word arriving at a full FIFO with no pop is dropped and sets sticky o_ovf.
module pix_word_packer #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_strb,
    input  logic [7:0]                    i_data,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [31:0]                   o_data,
    output logic                          o_eol,
    output logic                          o_eof,
    output logic                          o_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = PW + 1;

    // Entry layout: {eof, eol, data[31:0]}
    typedef logic [33:0] entry_t;

    logic [1:0]    lane;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [23:0]   asm_word;

    entry_t        mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          ovf;

    logic          last_col;
    logic          last_row;
    logic          push;
    logic          pop;
    logic          accept;
    entry_t        push_word;
    entry_t        head;

    // Position tags and push/pop decisions for the current cycle
    always_comb begin
        last_col  = (col == CW'(IMG_W - 1));
        last_row  = (row == RW'(IMG_H - 1));
        push      = i_strb && (lane == 2'd3);
        push_word = {last_col && last_row, last_col, i_data, asm_word};
        pop       = (count != '0) && o_ready;
        // At full, a same-cycle pop frees the slot the push is about to use
        accept    = push && ((count != LW'(FIFO_DEPTH)) || pop);
    end

    // Lane counter, assembly bytes and raster position; advance on every strobe even when a word is dropped
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lane     <= '0;
            col      <= '0;
            row      <= '0;
            asm_word <= '0;
        end else if (i_strb) begin
            lane <= lane + 2'd1;
            case (lane)
                2'd0:    asm_word[7:0]   <= i_data;
                2'd1:    asm_word[15:8]  <= i_data;
                2'd2:    asm_word[23:16] <= i_data;
                default: ;
            endcase
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because outputs are gated by o_valid
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (accept && !pop) begin
                count <= count + LW'(1);
            end else if (pop && !accept) begin
                count <= count - LW'(1);
            end
            if (push && !accept) begin
                ovf <= 1'b1;
            end
        end
    end

    // Show-ahead outputs driven from registered state only; zeroed while empty
    always_comb begin
        head    = mem[rd_ptr];
        o_valid = (count != '0);
        o_data  = o_valid ? head[31:0] : 32'h0;
        o_eol   = o_valid && head[32];
        o_eof   = o_valid && head[33];
        o_ovf   = ovf;
        o_level = count;
    end

endmodule

// File: tb/tb_pix_word_packer.sv
// Directed bench for pix_word_packer on a reduced 32x4 image (8 words per row, 32 per frame).
// Inputs change 1 time unit after the rising edge; outputs are checked there or captured on the falling edge.
// Popped words are logged by a monitor and compared against hand-derived expectations.
module tb_pix_word_packer;

    localparam int W   = 32;
    localparam int H   = 4;
    localparam int D   = 16;
    localparam int WPR = W / 4;
    localparam int WPF = WPR * H;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_strb;
    logic [7:0]  i_data;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic        o_eol;
    logic        o_eof;
    logic        o_ovf;
    logic [4:0]  o_level;

    int n_chk  = 0;
    int n_pass = 0;

    logic [33:0] got [$];

    pix_word_packer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_strb  (i_strb),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_eol   (o_eol),
        .o_eof   (o_eof),
        .o_ovf   (o_ovf),
        .o_level (o_level)
    );

    always #5 clk = ~clk;

    // Record every accepted word as {eof, eol, data}
    always @(negedge clk) begin
        if (reset_n && o_valid && o_ready) begin
            got.push_back({o_eof, o_eol, o_data});
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic [7:0] d, input int gap);
        i_strb = 1'b1;
        i_data = d;
        tick();
        i_strb = 1'b0;
        i_data = 8'hxx;
        repeat (gap) tick();
    endtask

    task automatic send_run(input int start, input int cnt, input int gap);
        logic [7:0] v;
        for (int i = 0; i < cnt; i++) begin
            v = 8'(start + i);
            send_pix(v, gap);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        i_strb  = 1'b0;
        i_data  = 8'h00;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Word n of a stream whose pixel value equals its index
    function automatic logic [33:0] exp_word(input int n);
        logic [31:0] d;
        logic        eol;
        logic        eof;
        for (int k = 0; k < 4; k++) begin
            d[8*k +: 8] = 8'(4 * n + k);
        end
        eol = ((n % WPR) == WPR - 1);
        eof = ((n % WPF) == WPF - 1);
        return {eof, eol, d};
    endfunction

    initial begin
        int eofs;
        reset_n = 1'b0;
        i_strb  = 1'b0;
        i_data  = 8'h00;
        o_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", o_valid, 0);
        check("rst_level", o_level, 0);
        check("rst_ovf",   o_ovf,   0);
        check("rst_data",  o_data,  0);
        check("rst_tags",  {o_eof, o_eol}, 0);

        // Single sparse word
        o_ready = 1'b1;
        got.delete();
        send_pix(8'h11, 16);
        send_pix(8'h22, 16);
        send_pix(8'h33, 16);
        check("t1_idle_valid", o_valid, 0);
        send_pix(8'h44, 0);
        check("t1_valid", o_valid, 1);
        check("t1_data",  o_data, 32'h44332211);
        check("t1_eol",   o_eol, 0);
        tick();
        check("t1_valid_drop", o_valid, 0);
        repeat (16) tick();
        check("t1_count", got.size(), 1);
        check("t1_ovf",   o_ovf, 0);

        // Full frame, back-to-back pixels
        do_reset();
        got.delete();
        send_run(0, W * H, 0);
        repeat (8) tick();
        check("t2_count", got.size(), WPF);
        for (int n = 0; n < got.size(); n++) begin
            check($sformatf("t2_word%0d", n), got[n], exp_word(n));
        end

        // Three frames, sparse strobes
        do_reset();
        got.delete();
        send_run(0, 3 * W * H, 16);
        repeat (8) tick();
        check("t3_count", got.size(), 3 * WPF);
        eofs = 0;
        for (int n = 0; n < got.size(); n++) begin
            if (got[n][33]) begin
                check($sformatf("t3_eof_pos%0d", eofs), n, (eofs + 1) * WPF - 1);
                eofs++;
            end
        end
        check("t3_eof_total", eofs, 3);
        check("t3_ovf", o_ovf, 0);

        // Overflow: 20 words into a 16-deep FIFO with no consumer
        do_reset();
        got.delete();
        o_ready = 1'b0;
        send_run(0, 80, 0);
        check("t4_level", o_level, 16);
        check("t4_ovf",   o_ovf, 1);
        check("t4_valid", o_valid, 1);
        o_ready = 1'b1;
        repeat (20) tick();
        send_run(80, 16, 0);
        repeat (8) tick();
        check("t4_count", got.size(), 20);
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("t4_word%0d", i), got[i], exp_word(i < 16 ? i : i + 4));
        end
        check("t4_ovf_sticky", o_ovf, 1);

        // Push and pop on the same edge while full
        do_reset();
        got.delete();
        o_ready = 1'b0;
        send_run(0, 64, 0);
        check("t5_full_level", o_level, 16);
        check("t5_full_ovf",   o_ovf, 0);
        send_run(64, 3, 0);
        i_strb  = 1'b1;
        i_data  = 8'd67;
        o_ready = 1'b1;
        tick();
        i_strb  = 1'b0;
        i_data  = 8'hxx;
        o_ready = 1'b0;
        check("t5_level", o_level, 16);
        check("t5_ovf",   o_ovf, 0);
        check("t5_head",  o_data, 32'h07060504);
        o_ready = 1'b1;
        repeat (24) tick();
        check("t5_count", got.size(), 17);
        if (got.size() == 17) begin
            check("t5_first", got[0],  exp_word(0));
            check("t5_last",  got[16], exp_word(16));
        end

        // Reset mid-word with words queued
        do_reset();
        got.delete();
        o_ready = 1'b0;
        send_run(0, 22, 0);
        check("t6_pre_level", o_level, 5);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t6_valid", o_valid, 0);
        check("t6_level", o_level, 0);
        check("t6_ovf",   o_ovf, 0);
        o_ready = 1'b1;
        send_pix(8'hA0, 0);
        send_pix(8'hA1, 0);
        send_pix(8'hA2, 0);
        send_pix(8'hA3, 0);
        send_run(4, W - 4, 0);
        repeat (8) tick();
        check("t6_count", got.size(), WPR);
        if (got.size() == WPR) begin
            check("t6_word0", got[0], {2'b00, 32'hA3A2A1A0});
            check("t6_mid_eol", got[WPR-2][32], 0);
            check("t6_row_end", got[WPR-1], {2'b01, 32'h1F1E1D1C});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
